// File: rtl/uart_bridge_pkg.sv
// Purpose: shared types and constants for the cont_2_uart bridge arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    GAP   = 3'd4
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_W     = 13;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_START_HOLD = 3;
  localparam int DEF_TIMEOUT    = 65535;

  // Start must sit low this many cycles between transactions so the bridge's
  // 2-flop edge detector always sees a fresh 0->1 edge.
  localparam int GAP_CYCLES = 2;

  // Read data returned with an error response (sliced down to DATA_W <= 64).
  localparam logic [63:0] ERR_RDATA = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: combinational round-robin pick, first set request at or after ptr_i.
// Latency: 0 cycles (pure combinational; the pointer register lives in the parent).
// Backpressure: none; a request not picked simply stays pending on req_i.
// Ports: req_i request vector, ptr_i search start, gnt_o one-hot pick,
//        idx_o picked index, vld_o any request present.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  always_comb begin
    int c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Walk candidates ptr, ptr+1, ... wrapping modulo NUM_REQ.
      c = int'(ptr_i) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!vld_o && req_i[c]) begin
        vld_o    = 1'b1;
        idx_o    = IDX_W'(c);
        gnt_o[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_bridge_arbiter.sv
// Purpose: shares one cont_2_uart host bridge between NUM_REQ requesters (round-robin).
// Latency: grant 1 cycle after request seen in IDLE; response 1 cycle after complete rises.
// Backpressure: one transaction in flight; requesters hold req_i until their grant pulse.
// Ports: clk_i/rst_ni (async active-low); req_i/we_i/addr_i/wdata_i packed per requester;
//        gnt_o/rvalid_o/err_o one-hot, rdata_o shared; br_* drive the bridge handshake.
// Option: define BRIDGE_TIMEOUT_EN to add the WAIT watchdog, error responses and stale guard.
module uart_bridge_arbiter
  import uart_bridge_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int START_HOLD     = DEF_START_HOLD,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic                      br_start_o,
  output logic [ADDR_W-1:0]         br_address_o,
  output logic [DATA_W-1:0]         br_data_o,
  output logic                      br_we_o,
  input  logic                      br_complete_i,
  input  logic [DATA_W-1:0]         br_read_data_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 8;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (START_HOLD < 2 || START_HOLD > 255) begin : g_bad_start_hold
    $error("START_HOLD must be in 2..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end
  if (DATA_W > 64) begin : g_bad_data_w
    $error("DATA_W must be <= 64");
  end

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, idx_q, arb_idx;
  logic [NUM_REQ-1:0] arb_gnt, gnt_q;
  logic               arb_vld;
  logic               complete_q, done;
  logic               grant_fire, resp_capture;
  logic               to_hit, issue_ok;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q, rdata_q, resp_dat;
  logic               we_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // Only a rising edge counts: a complete level left high by the previous
  // transaction must not finish the next one.
  assign done = br_complete_i & ~complete_q;

`ifdef BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt_q;
  logic        stale_q;
  logic        err_q;

  assign to_hit   = (state_q == WAIT) && !done && (to_cnt_q == TO_LIM);
  // A timed-out bridge may still finish late; hold off new grants until that
  // completion has been absorbed or a second timeout window has passed.
  assign issue_ok = !stale_q;
  assign resp_dat = to_hit ? ERR_RDATA[DATA_W-1:0] : (we_q ? '0 : br_read_data_i);
  assign err_o    = rvalid_o & {NUM_REQ{err_q}};

  // The same counter times WAIT and, afterwards, the stale window; the two
  // never overlap because no grant (hence no WAIT) happens while stale.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
      stale_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (resp_capture) err_q <= to_hit;
      if (to_hit) begin
        stale_q  <= 1'b1;
        to_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        to_cnt_q <= (state_d == WAIT) ? to_cnt_q + 16'd1 : '0;
      end else if (stale_q) begin
        if (done || to_cnt_q == TO_LIM) begin
          stale_q  <= 1'b0;
          to_cnt_q <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 16'd1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end
`else
  assign to_hit   = 1'b0;
  assign issue_ok = 1'b1;
  assign resp_dat = we_q ? '0 : br_read_data_i;
  assign err_o    = '0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_fire   = 1'b0;
    resp_capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_vld && issue_ok) begin
          grant_fire = 1'b1;
          cnt_d      = CNT_W'(START_HOLD - 1);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == '0) state_d = WAIT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WAIT: begin
        if (done || to_hit) begin
          resp_capture = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        cnt_d   = CNT_W'(GAP_CYCLES - 1);
        state_d = GAP;
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      gnt_q      <= '0;
      complete_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      complete_q <= br_complete_i;
      gnt_q      <= grant_fire ? arb_gnt : '0;
      if (grant_fire) begin
        idx_q  <= arb_idx;
        ptr_q  <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
        addr_q <= addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
        data_q <= wdata_i[int'(arb_idx)*DATA_W +: DATA_W];
        we_q   <= we_i[arb_idx];
      end
      if (resp_capture) rdata_q <= resp_dat;
    end
  end

  assign gnt_o        = gnt_q;
  assign rvalid_o     = (state_q == RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q) : '0;
  assign rdata_o      = rdata_q;
  assign br_start_o   = (state_q == ISSUE);
  assign br_address_o = addr_q;
  assign br_data_o    = data_q;
  assign br_we_o      = we_q;

endmodule

// File: tb/tb_uart_bridge_arbiter.sv
// Purpose: directed self-checking bench for uart_bridge_arbiter (2 requesters).
// Latency: checks grant, start-hold, response and timeout timing cycle by cycle.
// Backpressure: the bench plays the bridge by hand, driving complete/read data.
module tb_uart_bridge_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 32;

  logic                      clk_i;
  logic                      rst_ni;
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        we_i;
  logic [NUM_REQ*ADDR_W-1:0] addr_i;
  logic [NUM_REQ*DATA_W-1:0] wdata_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        rvalid_o;
  logic [DATA_W-1:0]         rdata_o;
  logic [NUM_REQ-1:0]        err_o;
  logic                      br_start_o;
  logic [ADDR_W-1:0]         br_address_o;
  logic [DATA_W-1:0]         br_data_o;
  logic                      br_we_o;
  logic                      br_complete_i;
  logic [DATA_W-1:0]         br_read_data_i;

  int tests_run;
  int tests_failed;

  uart_bridge_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .START_HOLD     (3),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .we_i           (we_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .gnt_o          (gnt_o),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .err_o          (err_o),
    .br_start_o     (br_start_o),
    .br_address_o   (br_address_o),
    .br_data_o      (br_data_o),
    .br_we_o        (br_we_o),
    .br_complete_i  (br_complete_i),
    .br_read_data_i (br_read_data_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Drive and sample 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Waits (bounded) for a grant pulse; returns 0 if none arrived.
  task automatic wait_gnt(output logic [NUM_REQ-1:0] g);
    int n;
    n = 0;
    g = gnt_o;
    while (g == '0 && n < 60) begin
      tick();
      n++;
      g = gnt_o;
    end
  endtask

  // Counts cycles with start high, leaving the bench in the first WAIT cycle.
  task automatic wait_start_low(output int n);
    n = 0;
    while (br_start_o && n < 20) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    br_complete_i = 1'b0; br_read_data_i = '0;
    #1;
    tests_run++;
    if ({gnt_o, rvalid_o, err_o, br_start_o, br_we_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 0", {gnt_o, rvalid_o, err_o, br_start_o, br_we_o});
    end
    tests_run++;
    if ({br_address_o, br_data_o, rdata_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: addr %h data %h rdata %h want 0", br_address_o, br_data_o, rdata_o);
    end
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    tests_run++;
    if (gnt_o !== 2'b00 || br_start_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: gnt %b start %b want 00/0", gnt_o, br_start_o);
    end
  endtask

  task automatic test_single_read();
    logic [NUM_REQ-1:0] g;
    int n;
    req_i = 2'b01; we_i = 2'b00;
    addr_i = {13'h0555, 13'h0123};
    wdata_i = {32'h11111111, 32'h22222222};
    wait_gnt(g);
    req_i = 2'b00;
    tests_run++;
    if (g !== 2'b01) begin
      tests_failed++;
      $display("FAIL read_gnt: got %b want 01", g);
    end
    tests_run++;
    if (br_address_o !== 13'h0123 || br_we_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_bus: addr %h we %b want 0123/0", br_address_o, br_we_o);
    end
    wait_start_low(n);
    tests_run++;
    if (n != 3) begin
      tests_failed++;
      $display("FAIL read_start_hold: got %0d cycles want 3", n);
    end
    tick(); tick();
    tests_run++;
    if (rvalid_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL read_early_rvalid: got %b want 00", rvalid_o);
    end
    br_read_data_i = 32'hCAFEF00D;
    br_complete_i = 1'b1;
    tick();
    tests_run++;
    if (rvalid_o !== 2'b01 || rdata_o !== 32'hCAFEF00D || err_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL read_resp: rvalid %b rdata %h err %b want 01/cafef00d/00", rvalid_o, rdata_o, err_o);
    end
    tick();
    br_complete_i = 1'b0;
    tests_run++;
    if (rvalid_o !== 2'b00 || rdata_o !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL read_resp_pulse: rvalid %b rdata %h want 00/cafef00d", rvalid_o, rdata_o);
    end
  endtask

  task automatic test_single_write();
    logic [NUM_REQ-1:0] g;
    logic stable;
    req_i = 2'b10; we_i = 2'b10;
    addr_i = {13'h1FFF, 13'h0AAA};
    wdata_i = {32'hA5A5A5A5, 32'h5A5A5A5A};
    wait_gnt(g);
    req_i = 2'b00;
    addr_i = '0; wdata_i = '0;
    tests_run++;
    if (g !== 2'b10) begin
      tests_failed++;
      $display("FAIL write_gnt: got %b want 10", g);
    end
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (br_address_o !== 13'h1FFF || br_data_o !== 32'hA5A5A5A5 || br_we_o !== 1'b1) stable = 1'b0;
      tick();
    end
    tests_run++;
    if (stable !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_bus_stable: addr %h data %h we %b want 1fff/a5a5a5a5/1", br_address_o, br_data_o, br_we_o);
    end
    br_read_data_i = 32'h12345678;
    br_complete_i = 1'b1;
    tick();
    tests_run++;
    if (rvalid_o !== 2'b10 || rdata_o !== 32'h0 || br_address_o !== 13'h1FFF) begin
      tests_failed++;
      $display("FAIL write_resp: rvalid %b rdata %h addr %h want 10/0/1fff", rvalid_o, rdata_o, br_address_o);
    end
    tick();
    br_complete_i = 1'b0;
  endtask

  task automatic test_contention();
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] exp_g;
    logic [DATA_W-1:0]  d;
    int n;
    req_i = 2'b11; we_i = 2'b00;
    addr_i = {13'h0022, 13'h0011};
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      d = 32'h10000000 + k;
      wait_gnt(g);
      tests_run++;
      if (g !== exp_g) begin
        tests_failed++;
        $display("FAIL rr_gnt%0d: got %b want %b", k, g, exp_g);
      end
      wait_start_low(n);
      tick();
      br_read_data_i = d;
      br_complete_i = 1'b1;
      tick();
      tests_run++;
      if (rvalid_o !== exp_g || rdata_o !== d) begin
        tests_failed++;
        $display("FAIL rr_resp%0d: rvalid %b rdata %h want %b/%h", k, rvalid_o, rdata_o, exp_g, d);
      end
      tick();
      br_complete_i = 1'b0;
    end
    req_i = 2'b00;
  endtask

  task automatic test_stale_complete();
    logic [NUM_REQ-1:0] g;
    logic quiet;
    int n;
    br_complete_i = 1'b1;
    tick(); tick(); tick(); tick();
    req_i = 2'b01; we_i = 2'b00;
    wait_gnt(g);
    req_i = 2'b00;
    tests_run++;
    if (g !== 2'b01) begin
      tests_failed++;
      $display("FAIL stale_gnt: got %b want 01", g);
    end
    wait_start_low(n);
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rvalid_o !== 2'b00) quiet = 1'b0;
      tick();
    end
    tests_run++;
    if (quiet !== 1'b1) begin
      tests_failed++;
      $display("FAIL stale_level_ignored: rvalid %b want 00 while complete held high", rvalid_o);
    end
    br_complete_i = 1'b0;
    tick(); tick();
    tests_run++;
    if (rvalid_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL stale_fall: rvalid %b want 00", rvalid_o);
    end
    br_read_data_i = 32'hDEADBEEF;
    br_complete_i = 1'b1;
    tick();
    tests_run++;
    if (rvalid_o !== 2'b01 || rdata_o !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL stale_fresh_edge: rvalid %b rdata %h want 01/deadbeef", rvalid_o, rdata_o);
    end
    tick();
    br_complete_i = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [NUM_REQ-1:0] g;
    logic quiet;
    int n;
    req_i = 2'b01; we_i = 2'b01;
    addr_i = {13'h0333, 13'h0777};
    wdata_i = {32'h0, 32'h87654321};
    wait_gnt(g);
    req_i = 2'b00;
    tests_run++;
    if (g !== 2'b01) begin
      tests_failed++;
      $display("FAIL rst_pre_gnt: got %b want 01", g);
    end
    wait_start_low(n);
    tick();
    rst_ni = 1'b0;
    #1;
    tests_run++;
    if ({gnt_o, rvalid_o, err_o, br_start_o, br_we_o} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_ctrl: got %b want 0", {gnt_o, rvalid_o, err_o, br_start_o, br_we_o});
    end
    tests_run++;
    if (br_address_o !== '0 || br_data_o !== '0 || rdata_o !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_data: addr %h data %h rdata %h want 0", br_address_o, br_data_o, rdata_o);
    end
    tick();
    rst_ni = 1'b1;
    br_complete_i = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rvalid_o !== 2'b00 || gnt_o !== 2'b00) quiet = 1'b0;
    end
    tests_run++;
    if (quiet !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_abandoned: rvalid %b gnt %b want 00/00", rvalid_o, gnt_o);
    end
    br_complete_i = 1'b0;
    req_i = 2'b11; we_i = 2'b00;
    wait_gnt(g);
    req_i = 2'b00;
    tests_run++;
    if (g !== 2'b01) begin
      tests_failed++;
      $display("FAIL rst_ptr: got gnt %b want 01", g);
    end
    wait_start_low(n);
    tick();
    br_read_data_i = 32'h0BADF00D;
    br_complete_i = 1'b1;
    tick();
    tests_run++;
    if (rvalid_o !== 2'b01 || rdata_o !== 32'h0BADF00D) begin
      tests_failed++;
      $display("FAIL rst_recover: rvalid %b rdata %h want 01/0badf00d", rvalid_o, rdata_o);
    end
    tick();
    br_complete_i = 1'b0;
  endtask

`ifdef BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    logic [NUM_REQ-1:0] g;
    logic quiet;
    int n;
    req_i = 2'b10; we_i = 2'b00;
    wait_gnt(g);
    req_i = 2'b00;
    tests_run++;
    if (g !== 2'b10) begin
      tests_failed++;
      $display("FAIL to_gnt: got %b want 10", g);
    end
    wait_start_low(n);
    n = 0;
    while (rvalid_o == 2'b00 && n < 300) begin
      tick();
      n++;
    end
    tests_run++;
    if (n != 100) begin
      tests_failed++;
      $display("FAIL to_latency: got %0d cycles want 100", n);
    end
    tests_run++;
    if (rvalid_o !== 2'b10 || err_o !== 2'b10 || rdata_o !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL to_resp: rvalid %b err %b rdata %h want 10/10/ffffffff", rvalid_o, err_o, rdata_o);
    end
    req_i = 2'b01;
    quiet = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (gnt_o !== 2'b00) quiet = 1'b0;
    end
    tests_run++;
    if (quiet !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_stale_block: gnt %b want 00 while stale", gnt_o);
    end
    br_read_data_i = 32'h77777777;
    br_complete_i = 1'b1;
    tick();
    tests_run++;
    if (rvalid_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL to_late_discard: rvalid %b want 00", rvalid_o);
    end
    wait_gnt(g);
    req_i = 2'b00;
    br_complete_i = 1'b0;
    tests_run++;
    if (g !== 2'b01) begin
      tests_failed++;
      $display("FAIL to_regrant: got %b want 01", g);
    end
    wait_start_low(n);
    tick();
    br_read_data_i = 32'h00000055;
    br_complete_i = 1'b1;
    tick();
    tests_run++;
    if (rvalid_o !== 2'b01 || err_o !== 2'b00 || rdata_o !== 32'h00000055) begin
      tests_failed++;
      $display("FAIL to_recover: rvalid %b err %b rdata %h want 01/00/00000055", rvalid_o, err_o, rdata_o);
    end
    tick();
    br_complete_i = 1'b0;
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_stale_complete();
    test_reset_mid_wait();
`ifdef BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/uart_bridge_arbiter.md
Name: uart_bridge_arbiter

Overview:
Shares the single cont_2_uart host bridge between NUM_REQ requesters, for example the Ibex instruction/data ports and a debug master.
- Picks a requester by round-robin and latches its command.
- Drives the bridge's level-sensitive start/complete handshake and holds address, data and we stable for the whole serial transaction.
- Returns read data or a write acknowledge to the requester that issued the command.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 13, bridge address width
DATA_W, 32, bridge data width
START_HOLD, 3, cycles br_start_o is held high per transaction (must be >= 2 to pass the bridge's 2-flop edge detector)
TIMEOUT_CYCLES, 65535, watchdog limit in cycles (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_i  in  NUM_REQ  per-requester request, held until grant
we_i  in  NUM_REQ  per-requester write enable
addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
wdata_i  in  NUM_REQ*DATA_W  packed write data
gnt_o  out  NUM_REQ  one-hot, one-cycle grant pulse
rvalid_o  out  NUM_REQ  one-hot, one-cycle response pulse
rdata_o  out  DATA_W  response data, valid with rvalid_o
err_o  out  NUM_REQ  error flag, valid with rvalid_o
br_start_o  out  1  to bridge start
br_address_o  out  ADDR_W  to bridge address
br_data_o  out  DATA_W  to bridge data
br_we_o  out  1  to bridge we_i
br_complete_i  in  1  from bridge complete
br_read_data_i  in  DATA_W  from bridge read_data_o

Behaviour:
- Reset: clock and reset are one clock domain; reset is asynchronous and active-low.
  - All outputs are 0 and the state is IDLE.
  - The round-robin pointer is 0 and complete_q is 0.
  - Reset mid-transaction abandons the transaction with no response.
- complete_q is a registered copy of br_complete_i. done = br_complete_i & ~complete_q, a rising edge. A complete level already high from the previous transaction is ignored.
- IDLE: if any req_i is set, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ. In that cycle:
  - pulse gnt_o[k];
  - latch addr, wdata, we and the index k;
  - set pointer to k+1 mod NUM_REQ;
  - go to ISSUE.
- ISSUE: br_start_o = 1 for START_HOLD cycles (down-counter), then go to WAIT.
- WAIT: br_start_o = 0. On done, capture rdata (br_read_data_i if read, 0 if write) and go to RESP.
- RESP: pulse rvalid_o[k] for 1 cycle with rdata_o; err_o[k] = 0. Then go to GAP.
- GAP: 2 cycles with start low, which guarantees the bridge sees a fresh 0->1 edge. Then go to IDLE.
- br_address_o, br_data_o and br_we_o are registered. They are stable from ISSUE through RESP and hold their last value otherwise.
- Latency:
  - grant is 1 cycle after req_i is seen in IDLE, so back-to-back grants are impossible;
  - rvalid comes 1 cycle after done;
  - minimum request-to-request spacing is START_HOLD + bridge time + 4 cycles.
- Simultaneous requests: round-robin order. A requester that drops req_i before grant is simply skipped.
- rdata_o holds its value after RESP until the next response.

Optional Feature:
BRIDGE_TIMEOUT_EN
- Defined:
  - A 16-bit counter runs in WAIT and clears on leaving WAIT.
  - When the count reaches TIMEOUT_CYCLES with no done, go to RESP with err_o[k] = 1 and rdata_o = all-ones.
  - A sticky stale flag is set. While stale is set, IDLE issues no grants. stale clears on the next done, which is discarded, or after a further TIMEOUT_CYCLES.
- Undefined: no counter; WAIT waits indefinitely; err_o is tied 0.

Decomposition:
- Package uart_bridge_pkg:
  - state enum arb_state_e {IDLE, ISSUE, WAIT, RESP, GAP};
  - localparams GAP_CYCLES = 2 and the default widths;
  - error fill value ERR_RDATA = all-ones.
- Sub-module rr_arbiter: request vector plus pointer in, one-hot grant plus index out. It is combinational; the pointer lives in the parent.

Test Plan:
1. Single read: req_i = 01, we = 0, addr = 0x0123; bridge model completes with 0xCAFEF00D -> gnt_o = 01; start high 3 cycles; rvalid_o = 01 with rdata_o = 0xCAFEF00D; err_o = 0.
2. Single write: req 1, addr = 0x1FFF, wdata = 0xA5A5A5A5 -> br_address_o and br_data_o stable until complete rises; rvalid_o[1] with rdata_o = 0.
3. Contention: req_i = 11 held -> grants alternate 0, 1, 0, 1 over 4 transactions; each rvalid goes only to the granted index.
4. Stale complete: br_complete_i stays high from the prior transaction and then falls/rises late -> no rvalid until the fresh rising edge.
5. Reset mid-WAIT: rst_ni low asynchronously -> all outputs 0 immediately, pointer = 0; after release the next request proceeds normally.
6. BRIDGE_TIMEOUT_EN with TIMEOUT_CYCLES = 100, bridge never completes -> rvalid with err = 1 and rdata = 0xFFFFFFFF 100 cycles into WAIT; no grant until stale clears.
